ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter. Sends one command byte (set LEDs 0xED, enable 0xF4,

---
 rtl/ps2_pkg.sv | 34 +++
 rtl/ps2_host_tx_if.sv | 23 ++
 rtl/ps2_line_filter.sv | 42 ++++
 rtl/ps2_host_tx.sv | 187 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM states, error codes, keyboard command bytes and
// the odd-parity helper. Used by the host transmitter and the keyboard receiver.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_WAIT1,
        ST_SHIFT,
        ST_ACK,
        ST_DONE,
        ST_ERR
    } tx_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_NO_CLK  = 2'b01,
        ERR_PKT_TMO = 2'b10,
        ERR_NO_ACK  = 2'b11
    } err_code_t;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] CMD_RESEND  = 8'hFE;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] ACK         = 8'hFA;

    // PS/2 frames carry odd parity: data bits plus parity hold an odd number of ones
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between a controller and the PS/2 host transmitter.
interface ps2_host_tx_if;
    import ps2_pkg::*;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;
    err_code_t  err_code;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, tx_busy, tx_done, tx_error, err_code
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, tx_busy, tx_done, tx_error, err_code
    );

endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus a glitch filter for one PS/2 line. The filtered
// level only changes after FILT_LEN consecutive samples disagree with it, and
// fall pulses for one cycle when the filtered level drops from 1 to 0.
module ps2_line_filter #(
    parameter int FILT_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic fall
);

    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(FILT_LEN - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // Synchronise the pin, then flip the level once enough disagreeing samples arrive
    always_ff @(posedge clk) begin
        if (reset) begin
            sync  <= 2'b11;
            level <= 1'b1;
            cnt   <= '0;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[0], din};
            fall <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= sync[1];
                cnt   <= '0;
                fall  <= level;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues request-to-send,
// shifts a command byte out on device clock falls and checks the device ACK.
// One timer is shared by the inhibit delay, the start and packet timeouts and
// the line-quiet count that gates tx_ready.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ        = 50_000_000,
    parameter int INHIBIT_US    = 120,
    parameter int START_TMO_US  = 15000,
    parameter int PACKET_TMO_US = 2000,
    parameter int LINE_IDLE_US  = 60,
    parameter int FILT_LEN      = 8
) (
    input  logic          CLOCK,
    input  logic          reset,
    ps2_host_tx_if.slave  bus,
    inout  wire           ps2ck,
    inout  wire           ps2dt
);

    localparam int CYC_PER_US     = CLK_HZ / 1_000_000;
    localparam int INHIBIT_CYC    = CYC_PER_US * INHIBIT_US;
    localparam int START_TMO_CYC  = CYC_PER_US * START_TMO_US;
    localparam int PACKET_TMO_CYC = CYC_PER_US * PACKET_TMO_US;
    localparam int LINE_IDLE_CYC  = CYC_PER_US * LINE_IDLE_US;
    localparam int TW             = $clog2(START_TMO_CYC + 1);

    localparam logic [TW-1:0] INHIBIT_LAST = TW'(INHIBIT_CYC - 1);
    localparam logic [TW-1:0] START_LAST   = TW'(START_TMO_CYC - 1);
    localparam logic [TW-1:0] PACKET_LAST  = TW'(PACKET_TMO_CYC - 1);
    localparam logic [TW-1:0] IDLE_MIN     = TW'(LINE_IDLE_CYC);

    tx_state_t  state, next_state;
    err_code_t  err_code_q, err_next;
    logic [TW-1:0] timer;
    logic [3:0] bit_cnt;
    logic [7:0] shreg;
    logic       par;
    logic       ck_level, ck_fall, dt_level, dt_fall;
    logic       lines_high, ready, accept;
    logic       ck_low, dt_low, done_pulse, err_pulse;

    ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_ck_filter (
        .clk   (CLOCK),
        .reset (reset),
        .din   (ps2ck),
        .level (ck_level),
        .fall  (ck_fall)
    );

    ps2_line_filter #(.FILT_LEN(1)) u_dt_filter (
        .clk   (CLOCK),
        .reset (reset),
        .din   (ps2dt),
        .level (dt_level),
        .fall  (dt_fall)
    );

    assign lines_high = ck_level && dt_level;
    assign ready      = (state == ST_IDLE) && (timer >= IDLE_MIN);
    assign accept     = ready && bus.tx_valid;

    // State register
    always_ff @(posedge CLOCK) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and line drive for each phase of the transfer
    always_comb begin
        next_state = state;
        err_next   = ERR_NONE;
        ck_low     = 1'b0;
        dt_low     = 1'b0;
        done_pulse = 1'b0;
        err_pulse  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) next_state = ST_INHIBIT;
            end
            ST_INHIBIT: begin
                ck_low = 1'b1;
                if (timer == INHIBIT_LAST) next_state = ST_REQ;
            end
            ST_REQ: begin
                ck_low     = 1'b1;
                dt_low     = 1'b1;
                next_state = ST_WAIT1;
            end
            ST_WAIT1: begin
                dt_low = 1'b1;
                if (ck_fall) begin
                    next_state = ST_SHIFT;
                end else if (timer == START_LAST) begin
                    next_state = ST_ERR;
                    err_next   = ERR_NO_CLK;
                end
            end
            ST_SHIFT: begin
                dt_low = (bit_cnt == 4'd9) ? ~par : ~shreg[0];
                if (ck_fall) begin
                    if (bit_cnt == 4'd9) next_state = ST_ACK;
                end else if (timer == PACKET_LAST) begin
                    next_state = ST_ERR;
                    err_next   = ERR_PKT_TMO;
                end
            end
            ST_ACK: begin
                if (ck_fall) begin
                    if (dt_level) begin
                        next_state = ST_ERR;
                        err_next   = ERR_NO_ACK;
                    end else begin
                        next_state = ST_DONE;
                    end
                end else if (timer == PACKET_LAST) begin
                    next_state = ST_ERR;
                    err_next   = ERR_PKT_TMO;
                end
            end
            ST_DONE: begin
                if (lines_high) begin
                    done_pulse = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            ST_ERR: begin
                err_pulse  = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Shared timer, bit counter, shift register and sticky error code
    always_ff @(posedge CLOCK) begin
        if (reset) begin
            timer      <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par        <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            // The packet timeout spans SHIFT and ACK, so that hand-over keeps counting
            if (state != next_state && !(state == ST_SHIFT && next_state == ST_ACK)) begin
                timer <= '0;
            end else if (state == ST_IDLE) begin
                if (!lines_high || ck_fall || dt_fall) begin
                    timer <= '0;
                end else if (timer < IDLE_MIN) begin
                    timer <= timer + TW'(1);
                end
            end else begin
                timer <= timer + TW'(1);
            end

            if (accept) begin
                shreg   <= bus.tx_data;
                par     <= odd_parity(bus.tx_data);
                bit_cnt <= '0;
            end else if (state == ST_WAIT1 && ck_fall) begin
                bit_cnt <= 4'd1;
            end else if (state == ST_SHIFT && ck_fall && bit_cnt < 4'd9) begin
                bit_cnt <= bit_cnt + 4'd1;
                shreg   <= {1'b1, shreg[7:1]};
            end

            if (next_state == ST_ERR && state != ST_ERR) begin
                err_code_q <= err_next;
            end
        end
    end

    assign bus.tx_ready = ready;
    assign bus.tx_busy  = (state != ST_IDLE);
    assign bus.tx_done  = done_pulse;
    assign bus.tx_error = err_pulse;
    assign bus.err_code = err_code_q;

    assign ps2ck = ck_low ? 1'b0 : 1'bz;
    assign ps2dt = dt_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for the PS/2 host transmitter: a device model clocks the frame,
// samples data on rising edges and optionally ACKs; done/error events go
// through an expected-result queue.
`timescale 1ns/1ps
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int CLK_HZ         = 1_000_000;
    localparam int INHIBIT_CYC    = 120;
    localparam int START_TMO_CYC  = 15000;
    localparam int PACKET_TMO_CYC = 2000;
    localparam int LINE_IDLE_CYC  = 60;
    localparam int HALF           = 40;

    localparam int M_ACK    = 0;
    localparam int M_SILENT = 1;
    localparam int M_NOACK  = 2;
    localparam int M_STOP4  = 3;

    typedef struct {
        logic [7:0] data;
        int         mode;
        logic       exp_done;
        logic [1:0] exp_code;
    } vec_t;

    typedef struct {
        logic       done;
        logic       err;
        logic [1:0] code;
    } exp_t;

    typedef struct {
        logic       done;
        logic       err;
        logic [1:0] code;
        int         cyc;
    } obs_t;

    logic CLOCK = 1'b0;
    logic reset = 1'b1;
    logic bfm_ck_low = 1'b0;
    logic bfm_dt_low = 1'b0;
    wire  ps2ck;
    wire  ps2dt;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    logic [1:0] last_code = 2'b00;

    exp_t exp_q[$];
    obs_t obs_q[$];
    vec_t vecs[6];

    pullup (ps2ck);
    pullup (ps2dt);
    assign ps2ck = bfm_ck_low ? 1'b0 : 1'bz;
    assign ps2dt = bfm_dt_low ? 1'b0 : 1'bz;

    ps2_host_tx_if bus ();

    ps2_host_tx #(
        .CLK_HZ        (CLK_HZ),
        .INHIBIT_US    (120),
        .START_TMO_US  (15000),
        .PACKET_TMO_US (2000),
        .LINE_IDLE_US  (60),
        .FILT_LEN      (8)
    ) dut (
        .CLOCK (CLOCK),
        .reset (reset),
        .bus   (bus),
        .ps2ck (ps2ck),
        .ps2dt (ps2dt)
    );

    always #5 CLOCK = ~CLOCK;

    always @(posedge CLOCK) cyc <= cyc + 1;

    // Record every done/error pulse with its cycle for the scoreboard
    always @(negedge CLOCK) begin
        if (bus.tx_done || bus.tx_error)
            obs_q.push_back('{bus.tx_done, bus.tx_error, bus.err_code, cyc});
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int lo, input int hi);
        checks++;
        if (actual < lo || actual > hi) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    task automatic waitObs(input int budget, output obs_t o, output bit ok);
        o  = '{1'b0, 1'b0, 2'b00, 0};
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (obs_q.size() > 0) begin
                o  = obs_q.pop_front();
                ok = 1'b1;
            end else begin
                @(negedge CLOCK);
            end
        end
    endtask

    task automatic waitReady(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (bus.tx_ready) ok = 1'b1;
            else @(negedge CLOCK);
        end
    endtask

    task automatic scoreCheck(input obs_t o, input bit ok);
        exp_t e;
        if (!ok) begin
            checkOutput("event_timeout", 0, 1, 1);
            return;
        end
        if (exp_q.size() == 0) begin
            checkOutput("unexpected_event", 1, 0, 0);
            return;
        end
        e = exp_q.pop_front();
        checkOutput("event_done", int'(o.done), int'(e.done), int'(e.done));
        checkOutput("event_error", int'(o.err), int'(e.err), int'(e.err));
        if (e.err) checkOutput("event_err_code", int'(o.code), int'(e.code), int'(e.code));
    endtask

    // One device clock pulse; optionally pull data low afterwards as the ACK
    task automatic bfmPulse(output logic sampled, input bit ack_after);
        bfm_ck_low = 1'b1;
        repeat (HALF) @(negedge CLOCK);
        sampled    = ps2dt;
        bfm_ck_low = 1'b0;
        if (ack_after) begin
            repeat (10) @(negedge CLOCK);
            bfm_dt_low = 1'b1;
            repeat (HALF - 10) @(negedge CLOCK);
        end else begin
            repeat (HALF) @(negedge CLOCK);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input bit hold);
        obs_t       o;
        bit         ok;
        int         cnt, t_rel, t_fall1, t_hi, npulse;
        logic [10:0] bits;
        logic       s;
        bits = '0;
        waitReady(3000, ok);
        checkOutput("ready_wait", int'(ok), 1, 1);
        if (!ok) return;
        bus.tx_data  = v.data;
        bus.tx_valid = 1'b1;
        @(posedge CLOCK);
        exp_q.push_back('{v.exp_done, !v.exp_done, v.exp_code});
        @(negedge CLOCK);
        if (!hold) bus.tx_valid = 1'b0;
        checkOutput("busy_after_accept", int'(bus.tx_busy), 1, 1);
        checkOutput("ck_low_after_accept", int'(ps2ck), 0, 0);
        cnt = 0;
        while (ps2ck == 1'b0 && ps2dt == 1'b1 && cnt < 1000) begin
            cnt++;
            @(negedge CLOCK);
        end
        checkOutput("inhibit_len", cnt, INHIBIT_CYC - 1, INHIBIT_CYC + 1);
        checkOutput("req_ck_low", int'(ps2ck), 0, 0);
        cnt = 0;
        while (ps2ck == 1'b0 && cnt < 10) begin
            cnt++;
            @(negedge CLOCK);
        end
        t_rel = cyc;
        checkOutput("start_bit_held", int'(ps2dt), 0, 0);

        if (v.mode == M_SILENT) begin
            waitObs(START_TMO_CYC + 100, o, ok);
            if (ok) checkOutput("start_tmo_time", o.cyc - t_rel, START_TMO_CYC - 5, START_TMO_CYC + 5);
            scoreCheck(o, ok);
            @(negedge CLOCK);
            checkOutput("lines_released", int'({ps2ck, ps2dt}), 3, 3);
        end else begin
            repeat (20) @(negedge CLOCK);
            t_fall1 = cyc;
            npulse  = (v.mode == M_STOP4) ? 4 : 11;
            for (int p = 1; p <= npulse; p++) begin
                bfmPulse(s, (p == 10) && (v.mode == M_ACK));
                bits[p-1] = s;
            end
            if (v.mode == M_STOP4) begin
                waitObs(PACKET_TMO_CYC + 200, o, ok);
                if (ok) checkOutput("pkt_tmo_time", o.cyc - t_fall1, PACKET_TMO_CYC - 5, PACKET_TMO_CYC + 30);
                scoreCheck(o, ok);
            end else begin
                for (int i = 0; i < 8; i++)
                    checkOutput($sformatf("data_bit%0d", i), int'(bits[i]), int'(v.data[i]), int'(v.data[i]));
                checkOutput("parity_bit", int'(bits[8]), int'(~^v.data), int'(~^v.data));
                checkOutput("stop_bit", int'(bits[9]), 1, 1);
                if (v.mode == M_ACK) begin
                    t_hi       = cyc;
                    bfm_dt_low = 1'b0;
                    waitObs(200, o, ok);
                    if (ok) checkOutput("done_latency", o.cyc - t_hi, 0, 20);
                    scoreCheck(o, ok);
                end else begin
                    t_hi = cyc - HALF;
                    waitObs(50, o, ok);
                    scoreCheck(o, ok);
                    waitReady(500, ok);
                    checkOutput("ready_after_error", cyc - t_hi, LINE_IDLE_CYC, LINE_IDLE_CYC + 20);
                end
            end
        end
        if (hold) bus.tx_valid = 1'b0;
        repeat (5) @(negedge CLOCK);
        checkOutput("single_event", obs_q.size(), 0, 0);
        if (!v.exp_done) last_code = v.exp_code;
        checkOutput("err_code_hold", int'(bus.err_code), int'(last_code), int'(last_code));
    endtask

    initial begin
        logic s;
        bit   ok;
        int   cnt;

        vecs[0] = '{CMD_SET_LED, M_ACK,    1'b1, 2'b00};
        vecs[1] = '{CMD_ENABLE,  M_ACK,    1'b1, 2'b00};
        vecs[2] = '{8'h00,       M_ACK,    1'b1, 2'b00};
        vecs[3] = '{CMD_RESEND,  M_SILENT, 1'b0, 2'b01};
        vecs[4] = '{CMD_RESET,   M_NOACK,  1'b0, 2'b11};
        vecs[5] = '{CMD_SET_LED, M_STOP4,  1'b0, 2'b10};

        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
        reset        = 1'b1;
        repeat (3) @(negedge CLOCK);
        $display("[TB] reset state");
        checkOutput("reset_ready", int'(bus.tx_ready), 0, 0);
        checkOutput("reset_busy", int'(bus.tx_busy), 0, 0);
        checkOutput("reset_done", int'(bus.tx_done), 0, 0);
        checkOutput("reset_error", int'(bus.tx_error), 0, 0);
        checkOutput("reset_err_code", int'(bus.err_code), 0, 0);
        checkOutput("reset_lines", int'({ps2ck, ps2dt}), 3, 3);
        reset = 1'b0;

        // Request while the line-quiet period is still running must be dropped
        @(negedge CLOCK);
        bus.tx_valid = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLOCK);
            if (ps2ck == 1'b0 || bus.tx_busy) cnt++;
        end
        bus.tx_valid = 1'b0;
        checkOutput("valid_not_ready_ignored", cnt, 0, 0);

        for (int i = 0; i < 6; i++) begin
            $display("[TB] vector %0d data=%02h mode=%0d", i, vecs[i].data, vecs[i].mode);
            applyStimulus(vecs[i], 1'b0);
        end

        $display("[TB] tx_valid held through a transfer");
        applyStimulus('{CMD_ENABLE, M_ACK, 1'b1, 2'b00}, 1'b1);
        cnt = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge CLOCK);
            if (ps2ck == 1'b0 || bus.tx_busy) cnt++;
        end
        checkOutput("held_valid_one_transfer", cnt, 0, 0);

        $display("[TB] reset during bit 5");
        waitReady(3000, ok);
        checkOutput("ready_before_abort", int'(ok), 1, 1);
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b1;
        @(posedge CLOCK);
        @(negedge CLOCK);
        bus.tx_valid = 1'b0;
        cnt = 0;
        while (!(ps2ck == 1'b1 && ps2dt == 1'b0) && cnt < 300) begin
            cnt++;
            @(negedge CLOCK);
        end
        repeat (20) @(negedge CLOCK);
        for (int p = 1; p <= 4; p++) bfmPulse(s, 1'b0);
        bfm_ck_low = 1'b1;
        repeat (HALF) @(negedge CLOCK);
        bfm_ck_low = 1'b0;
        repeat (10) @(negedge CLOCK);
        checkOutput("bit_driven_before_reset", int'(ps2dt), 0, 0);
        reset = 1'b1;
        @(negedge CLOCK);
        checkOutput("lines_after_reset", int'({ps2ck, ps2dt}), 3, 3);
        checkOutput("busy_after_reset", int'(bus.tx_busy), 0, 0);
        repeat (2) @(negedge CLOCK);
        reset     = 1'b0;
        last_code = 2'b00;
        repeat (200) @(negedge CLOCK);
        checkOutput("no_event_after_reset", obs_q.size(), 0, 0);
        checkOutput("err_code_after_reset", int'(bus.err_code), 0, 0);

        applyStimulus('{CMD_RESET, M_ACK, 1'b1, 2'b00}, 1'b0);
        checkOutput("scoreboard_empty", exp_q.size(), 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
